id_ex_hazard_ctrl: RTL and testbench

//  Sequences the ID/EX decode pipeline register and the IF/ID and PC stages of the rv32i 5-stage pipe.

---
 rtl/id_ex_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl
//
// Pipeline sequencing control for the ID/EX decode register and the IF/ID and PC stages of the
// rv32i 5-stage pipe. It detects load-use hazards between ID and EX and inserts LOAD_USE_STALL
// bubbles. It squashes wrong-path instructions when EX redirects the PC. It freezes the front end
// while data memory is busy. Only enables and flushes are produced here; the pipeline registers
// themselves hold the data.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2   source registers of the instruction in ID
//   id_use_rs1/2    the ID instruction actually reads that source
//   ex_load         ID/EX holds a load
//   ex_reg_write    ID/EX instruction writes rd
//   ex_rd           destination register of the ID/EX instruction
//   ex_redirect     EX redirects the PC this cycle (taken branch, jal, jalr)
//   dmem_busy       data memory not ready; hold everything
//   pc_en           PC load enable
//   if_id_en        IF/ID load enable
//   if_id_flush     load a NOP into IF/ID
//   id_ex_en        ID/EX load enable
//   id_ex_flush     load all-zero controls (a bubble) into ID/EX
//   ctrl_state      0 RUN, 1 LU_STALL, 2 MEM_WAIT
//   perf_stalls     load-use bubbles inserted (wraps)
//   perf_flushes    redirect squashes applied (wraps)
//
// Build option
//   HAZARD_PERF_EN  when defined, builds the two performance counters; otherwise they read 0.

module id_ex_hazard_ctrl #(
    parameter int unsigned REG_ADDR       = 5,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned CNT_WIDTH      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                ex_load,
    input  logic                ex_reg_write,
    input  logic [REG_ADDR-1:0] ex_rd,
    input  logic                ex_redirect,
    input  logic                dmem_busy,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_en,
    output logic                id_ex_flush,
    output logic [1:0]          ctrl_state,
    output logic [31:0]         perf_stalls,
    output logic [31:0]         perf_flushes
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StLuStall = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;

    // Remaining bubbles after the first one, loaded when the hazard is detected.
    localparam logic [CNT_WIDTH-1:0] CntInit = CNT_WIDTH'(LOAD_USE_STALL - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [1:0]           saved_q, saved_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           eff_state;
    logic                 hazard;

    assign hazard = ex_load & ex_reg_write & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Once memory releases, MEM_WAIT resumes whatever the pipe was doing before the freeze.
    assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ctrl_state  = state_q;
        state_d     = state_q;
        saved_d     = saved_q;
        cnt_d       = cnt_q;

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ctrl_state  = StRun;
            state_d     = StRun;
            saved_d     = StRun;
            cnt_d       = '0;
        end else if (dmem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            state_d  = StMemWait;
            if (state_q != StMemWait) begin
                saved_d = state_q;
            end
        end else if (ex_redirect) begin
            // Redirect beats a pending or newly detected hazard; the stall is abandoned.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = StRun;
            cnt_d       = '0;
        end else if (eff_state == StLuStall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (cnt_q <= CntOne) begin
                state_d = StRun;
                cnt_d   = '0;
            end else begin
                state_d = StLuStall;
                cnt_d   = cnt_q - CntOne;
            end
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_USE_STALL == 1) begin
                state_d = StRun;
                cnt_d   = '0;
            end else begin
                state_d = StLuStall;
                cnt_d   = CntInit;
            end
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            saved_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stalls_q, perf_flushes_q;
    logic        stall_evt, flush_evt;

    // A bubble is the only case flushing ID/EX without flushing IF/ID; a redirect is the only
    // flush with the PC advancing. Reset and dmem_busy match neither pattern.
    assign stall_evt = id_ex_flush & ~if_id_flush;
    assign flush_evt = if_id_flush & pc_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (stall_evt) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
            if (flush_evt) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`else
    assign perf_stalls  = 32'd0;
    assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: a per-cycle vector table against a LOAD_USE_STALL=3
// instance, plus hand sequences for single-bubble, memory freeze, redirect and reset cases.

module tb_id_ex_hazard_ctrl;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
    localparam logic [4:0] NORM = 5'b11010;
    localparam logic [4:0] BUB  = 5'b00011;
    localparam logic [4:0] RED  = 5'b11111;
    localparam logic [4:0] HOLD = 5'b00000;
    localparam logic [4:0] RSTO = 5'b00101;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_load, ex_reg_write, ex_redirect, dmem_busy;

    logic        pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1;
    logic [1:0]  ctrl_state1;
    logic [31:0] perf_stalls1, perf_flushes1;
    logic        pc_en3, if_id_en3, if_id_flush3, id_ex_en3, id_ex_flush3;
    logic [1:0]  ctrl_state3;
    logic [31:0] perf_stalls3, perf_flushes3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl #(.REG_ADDR(5), .LOAD_USE_STALL(1), .CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_load(ex_load),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .dmem_busy(dmem_busy), .pc_en(pc_en1), .if_id_en(if_id_en1),
        .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1), .id_ex_flush(id_ex_flush1),
        .ctrl_state(ctrl_state1), .perf_stalls(perf_stalls1), .perf_flushes(perf_flushes1)
    );

    id_ex_hazard_ctrl #(.REG_ADDR(5), .LOAD_USE_STALL(3), .CNT_WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_load(ex_load),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .dmem_busy(dmem_busy), .pc_en(pc_en3), .if_id_en(if_id_en3),
        .if_id_flush(if_id_flush3), .id_ex_en(id_ex_en3), .id_ex_flush(id_ex_flush3),
        .ctrl_state(ctrl_state3), .perf_stalls(perf_stalls3), .perf_flushes(perf_flushes3)
    );

    typedef struct {
        logic       rst, busy, redir;
        logic [4:0] rs1, rs2;
        logic       use1, use2, load, rw;
        logic [4:0] rd;
        logic [4:0] outs;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic r, input logic b, input logic rd_ir,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic u1, input logic u2, input logic ld, input logic w,
                                input logic [4:0] d, input logic [4:0] o, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.busy = b; v.redir = rd_ir; v.rs1 = s1; v.rs2 = s2;
        v.use1 = u1; v.use2 = u2; v.load = ld; v.rw = w; v.rd = d; v.outs = o; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; dmem_busy = v.busy; ex_redirect = v.redir;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_load = v.load; ex_reg_write = v.rw; ex_rd = v.rd;
    endtask

    // Input shorthands for the hand sequences.
    task automatic set_in(input logic r, input logic b, input logic rd_ir, input logic haz);
        vec_t v;
        v = mk(r, b, rd_ir, haz ? 5'd5 : 5'd0, 5'd0, haz, 1'b0, haz, haz, haz ? 5'd5 : 5'd0,
               5'd0, 2'd0);
        drive(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [4:0] o, input logic [1:0] st);
        check(name, {25'd0, pc_en3, if_id_en3, if_id_flush3, id_ex_en3, id_ex_flush3,
                     ctrl_state3}, {25'd0, o, st});
    endtask

    task automatic chk1(input string name, input logic [4:0] o, input logic [1:0] st);
        check(name, {25'd0, pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1,
                     ctrl_state1}, {25'd0, o, st});
    endtask

    // Sample mid-cycle, then advance past the next rising edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             rst b  rd rs1   rs2   u1 u2 ld rw rd    outs  st
        vecs[0]  = mk(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, RSTO, 2'd0);
        vecs[1]  = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[2]  = mk(0, 0, 0, 5'd0, 5'd0, 1, 0, 1, 1, 5'd0, NORM, 2'd0); // rd=x0
        vecs[3]  = mk(0, 0, 0, 5'd6, 5'd0, 1, 0, 1, 1, 5'd5, NORM, 2'd0); // no match
        vecs[4]  = mk(0, 0, 0, 5'd6, 5'd5, 1, 0, 1, 1, 5'd5, NORM, 2'd0); // rs2 unused
        vecs[5]  = mk(0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 0, 5'd5, NORM, 2'd0); // no reg_write
        vecs[6]  = mk(0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 1, 5'd5, BUB,  2'd0); // rs2 hazard
        vecs[7]  = mk(0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 1, 5'd5, BUB,  2'd1);
        vecs[8]  = mk(0, 0, 0, 5'd0, 5'd5, 0, 1, 1, 1, 5'd5, BUB,  2'd1);
        vecs[9]  = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[10] = mk(0, 0, 1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, RED,  2'd0); // redirect+hazard
        vecs[11] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[12] = mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, BUB,  2'd0);
        vecs[13] = mk(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, RED,  2'd1); // redirect in stall
        vecs[14] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[15] = mk(0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, HOLD, 2'd0);
        vecs[16] = mk(0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, HOLD, 2'd2);
        vecs[17] = mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, BUB,  2'd2); // hazard on release
        vecs[18] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, BUB,  2'd1);
        vecs[19] = mk(0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, HOLD, 2'd1);
        vecs[20] = mk(0, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, HOLD, 2'd2); // busy beats redirect
        vecs[21] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, BUB,  2'd2);
        vecs[22] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[23] = mk(0, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, HOLD, 2'd0);
        vecs[24] = mk(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, RED,  2'd2);
        vecs[25] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);
        vecs[26] = mk(1, 0, 0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, RSTO, 2'd0); // rst beats hazard
        vecs[27] = mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, BUB,  2'd0);
        vecs[28] = mk(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, RSTO, 2'd0); // rst mid-stall
        vecs[29] = mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, NORM, 2'd0);

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i]);
            settle();
            chk3($sformatf("vec%0d", i), vecs[i].outs, vecs[i].st);
            step();
        end

        // T1: single-bubble instance.
        set_in(1, 0, 0, 0); step();
        set_in(0, 0, 0, 1); settle(); chk1("t1_bubble", BUB, 2'd0); step();
        set_in(0, 0, 0, 0); settle(); chk1("t1_run", NORM, 2'd0); step();
        check("t1_perf_stalls", perf_stalls1, PERF ? 32'd1 : 32'd0);

        // T2 + T5: three bubbles with a 4-cycle memory freeze after the second one.
        set_in(1, 0, 0, 0); step();
        set_in(0, 0, 0, 1); settle(); chk3("t5_bub1", BUB, 2'd0); step();
        set_in(0, 0, 0, 0); settle(); chk3("t5_bub2", BUB, 2'd1); step();
        set_in(0, 1, 0, 0); settle(); chk3("t5_hold0", HOLD, 2'd1); step();
        for (int k = 1; k < 4; k++) begin
            settle(); chk3($sformatf("t5_hold%0d", k), HOLD, 2'd2); step();
        end
        set_in(0, 0, 0, 0); settle(); chk3("t5_bub3", BUB, 2'd2); step();
        settle(); chk3("t5_run", NORM, 2'd0);
        check("t5_perf_stalls", perf_stalls3, PERF ? 32'd3 : 32'd0);
        check("t5_perf_flushes", perf_flushes3, 32'd0);
        step();

        // T4: redirect and hazard together.
        set_in(1, 0, 0, 0); step();
        set_in(0, 0, 1, 1); settle(); chk3("t4_redirect", RED, 2'd0); step();
        set_in(0, 0, 0, 0); settle(); chk3("t4_run", NORM, 2'd0);
        check("t4_perf_stalls", perf_stalls3, 32'd0);
        check("t4_perf_flushes", perf_flushes3, PERF ? 32'd1 : 32'd0);
        step();

        // T6: reset during LU_STALL.
        set_in(0, 0, 0, 1); settle(); chk3("t6_bub1", BUB, 2'd0); step();
        set_in(0, 0, 0, 0); settle(); chk3("t6_bub2", BUB, 2'd1); step();
        set_in(1, 0, 0, 0); settle(); chk3("t6_rst0", RSTO, 2'd0); step();
        settle(); chk3("t6_rst1", RSTO, 2'd0); step();
        set_in(0, 0, 0, 0); settle(); chk3("t6_run", NORM, 2'd0);
        check("t6_perf_stalls", perf_stalls3, 32'd0);
        check("t6_perf_flushes", perf_flushes3, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
